// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // funct3 size codes
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Byte-lane enables for an access of the given size at byte offset off.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        case (size[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Word-organised data RAM: byte-enable synchronous write, registered read.
// Contents are never reset.
module dmem_ram_bank #(
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [3:0]                 be,
    input  logic                       re,
    input  logic [DMEM_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);

    logic [31:0] mem [DMEM_DEPTH];

    // Write enabled lanes and capture the addressed word on a read.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target with programmable access latency, request checking,
// byte-lane steering and sign/zero extension of load data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DMEM_DEPTH      = 1024,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int RD_LATENCY      = 2,
    parameter int WR_LATENCY      = 1
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = DMEM_ADDR_WIDTH;
    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);
    localparam logic [3:0] WR_LAT = 4'(WR_LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, access, req_err;
    logic [3:0]  req_lat;

    logic        wr_p0, err_p0;
    logic [2:0]  size_p0;
    logic [AW+1:0] addr_p0;
    logic [31:0] wdata_p0;

    logic        acc_wr;
    logic [2:0]  acc_size;
    logic [AW+1:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] ram_q;

    function automatic logic chk_err(input logic w, input logic [2:0] sz, input logic [31:0] a);
        logic bad;
        bad = (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111);
        bad |= w && sz[2];
        bad |= (sz[1:0] == 2'b01) && a[0];
        bad |= (sz == SZ_W) && (a[1:0] != 2'b00);
        bad |= (a[31:AW+2] != '0);
        return bad;
    endfunction

    // Aligned word index, folded back into the array when it is not a power of two.
    function automatic logic [AW-1:0] word_idx(input logic [AW+1:0] a);
        if (DMEM_DEPTH < (1 << AW)) return AW'(32'(a[AW+1:2]) % DMEM_DEPTH);
        return a[AW+1:2];
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] sz, input logic [31:0] wd);
        case (sz[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] sz, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (sz)
            SZ_B:    ext = b;
            SZ_H:    ext = h;
            SZ_BU:   ext = {24'd0, sh[7:0]};
            SZ_HU:   ext = {16'd0, sh[15:0]};
            default: ext = word;
        endcase
        return ext;
    endfunction

    assign req_ready = reset_b && (state_q == IDLE);
    assign req_err   = chk_err(req_write, req_size, req_addr);
    assign req_lat   = req_write ? WR_LAT : RD_LAT;

    // A zero-latency access uses the live request; later accesses use the latched one.
    assign acc_wr    = (state_q == IDLE) ? req_write          : wr_p0;
    assign acc_size  = (state_q == IDLE) ? req_size           : size_p0;
    assign acc_addr  = (state_q == IDLE) ? req_addr[AW+1:0]   : addr_p0;
    assign acc_wdata = (state_q == IDLE) ? req_wdata          : wdata_p0;

    // Next-state, latency countdown and access strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_lat == 4'd0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = req_lat - 4'd1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset abandons any request in flight.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the accepted request and its check result.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0    <= req_write;
            size_p0  <= req_size;
            addr_p0  <= req_addr[AW+1:0];
            wdata_p0 <= req_wdata;
            err_p0   <= req_err;
        end
    end

    dmem_ram_bank #(
        .DMEM_DEPTH      (DMEM_DEPTH),
        .DMEM_ADDR_WIDTH (DMEM_ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (access && acc_wr),
        .be    (byte_en(acc_size, acc_addr[1:0])),
        .re    (access && !acc_wr),
        .addr  (word_idx(acc_addr)),
        .wdata (store_lanes(acc_size, acc_wdata)),
        .rdata (ram_q)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_p0;
    assign rsp_rdata = (rsp_valid && !err_p0 && !wr_p0) ? load_ext(size_p0, addr_p0[1:0], ram_q)
                                                        : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: default latencies plus a zero-latency instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_b;

    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [2:0]  z_req_size;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10), .RD_LATENCY(2), .WR_LATENCY(1)) u_dut (
        .clk(clk), .reset_b(reset_b),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DMEM_DEPTH(1024), .DMEM_ADDR_WIDTH(10), .RD_LATENCY(0), .WR_LATENCY(0)) u_dut0 (
        .clk(clk), .reset_b(reset_b),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_size(z_req_size), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction on u_dut; lat counts clock edges from the accepting edge
    // (inclusive) to the edge after which rsp_valid is seen.
    task automatic xact(input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n), 32'd0);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        reset_b = 1'b0;
        req_valid = 0; req_write = 0; req_size = SZ_W; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_size = SZ_W; z_req_addr = 0; z_req_wdata = 0;
        z_rsp_ready = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        reset_b = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        chk("valid_after_rst", {31'd0, rsp_valid}, 32'd0);

        // 1: word store / load and latency
        xact(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_lat", 32'(lat), 32'd2);
        xact(1'b0, SZ_W, 32'h10, 32'h0, rd, er, lat);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);
        chk("lw_lat", 32'(lat), 32'd3);

        // 2: byte store, sign/zero-extending loads
        xact(1'b1, SZ_B, 32'h13, 32'h00000080, rd, er, lat);
        chk("sb_err", {31'd0, er}, 32'd0);
        xact(1'b0, SZ_B, 32'h13, 32'h0, rd, er, lat);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        xact(1'b0, SZ_BU, 32'h13, 32'h0, rd, er, lat);
        chk("lbu_rdata", rd, 32'h00000080);
        xact(1'b0, SZ_W, 32'h10, 32'h0, rd, er, lat);
        chk("lw_after_sb", rd, 32'h80ADBEEF);
        xact(1'b0, SZ_H, 32'h12, 32'h0, rd, er, lat);
        chk("lh_hi", rd, 32'hFFFF80AD);
        xact(1'b0, SZ_HU, 32'h10, 32'h0, rd, er, lat);
        chk("lhu_lo", rd, 32'h0000BEEF);

        // 3: rejected requests
        xact(1'b0, SZ_H, 32'h11, 32'h0, rd, er, lat);
        chk("lh_mis_err", {31'd0, er}, 32'd1);
        chk("lh_mis_rdata", rd, 32'd0);
        chk("lh_mis_lat", 32'(lat), 32'd1);
        xact(1'b1, SZ_W, 32'h12, 32'h11111111, rd, er, lat);
        chk("sw_mis_err", {31'd0, er}, 32'd1);
        xact(1'b0, SZ_W, 32'h10000, 32'h0, rd, er, lat);
        chk("lw_range_err", {31'd0, er}, 32'd1);
        chk("lw_range_rdata", rd, 32'd0);
        xact(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        chk("ill_size_err", {31'd0, er}, 32'd1);
        xact(1'b1, SZ_HU, 32'h10, 32'h22222222, rd, er, lat);
        chk("store_hu_err", {31'd0, er}, 32'd1);
        xact(1'b0, SZ_W, 32'h10, 32'h0, rd, er, lat);
        chk("mem_unchanged", rd, 32'h80ADBEEF);

        // 4: response back-pressure
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_W; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0]; req_write = 1'b1; req_size = SZ_W; req_addr = 32'h10; req_wdata = 32'h0;
            @(negedge clk);
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, 32'h80ADBEEF);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_hs_rdata", rsp_rdata, 32'd0);
        chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
        xact(1'b0, SZ_W, 32'h10, 32'h0, rd, er, lat);
        chk("stall_no_store", rd, 32'h80ADBEEF);

        // 5: reset during a pending store
        xact(1'b1, SZ_W, 32'h20, 32'h12345678, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_W; req_addr = 32'h20; req_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset_b = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        chk("midrst_ready_rel", {31'd0, req_ready}, 32'd1);
        chk("midrst_valid_rel", {31'd0, rsp_valid}, 32'd0);
        xact(1'b0, SZ_W, 32'h20, 32'h0, rd, er, lat);
        chk("midrst_old_val", rd, 32'h12345678);

        // 6: zero-latency instance, back-to-back SH / LHU
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_size = SZ_H;
        z_req_addr = 32'h22; z_req_wdata = 32'h00008001; z_rsp_ready = 1'b1;
        @(negedge clk);
        chk("z_sh_valid", {31'd0, z_rsp_valid}, 32'd1);
        chk("z_sh_err", {31'd0, z_rsp_err}, 32'd0);
        chk("z_sh_rdata", z_rsp_rdata, 32'd0);
        chk("z_sh_ready", {31'd0, z_req_ready}, 32'd0);
        z_req_write = 1'b0; z_req_size = SZ_HU;
        @(negedge clk);
        chk("z_gap_valid", {31'd0, z_rsp_valid}, 32'd0);
        chk("z_gap_ready", {31'd0, z_req_ready}, 32'd1);
        @(negedge clk);
        chk("z_lhu_valid", {31'd0, z_rsp_valid}, 32'd1);
        chk("z_lhu_rdata", z_rsp_rdata, 32'h00008001);
        chk("z_lhu_err", {31'd0, z_rsp_err}, 32'd0);
        z_req_valid = 1'b0;
        @(negedge clk);
        chk("z_end_valid", {31'd0, z_rsp_valid}, 32'd0);
        z_rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
